control_unit: RTL and testbench

- Multi-cycle Moore/Mealy control FSM for the 8-bit processing unit.
- Consumes `instruction` and `Zflag` from the processing unit. Drives every register load, PC control and bus-mux select the processing unit takes, plus the memory `write` strobe.
- Sequences fetch, decode, execute, memory read/write and branch as a fixed state walk.

---
 rtl/control_unit_if.sv | 40 ++++
 rtl/control_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_control_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// Processing-unit control bus: IR/flag inputs to the controller, loads/selects back.
// master = control_unit side, slave = datapath side.
interface control_unit_if #(
  parameter int word_size = 8,
  parameter int Sel1_size = 3,
  parameter int Sel2_size = 2
);
  logic [word_size-1:0] instruction;
  logic                 Zflag;
  logic                 Load_R0;
  logic                 Load_R1;
  logic                 Load_R2;
  logic                 Load_R3;
  logic                 Load_PC;
  logic                 Inc_PC;
  logic [Sel1_size-1:0] Sel_Bus_1_Mux;
  logic [Sel2_size-1:0] Sel_Bus_2_Mux;
  logic                 Load_IR;
  logic                 Load_Add_R;
  logic                 Load_Reg_Y;
  logic                 Load_Reg_Z;
  logic                 write;
  logic                 err;

  modport master (
    input  instruction, Zflag,
    output Load_R0, Load_R1, Load_R2, Load_R3,
    output Load_PC, Inc_PC, Sel_Bus_1_Mux, Sel_Bus_2_Mux,
    output Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z,
    output write, err
  );

  modport slave (
    output instruction, Zflag,
    input  Load_R0, Load_R1, Load_R2, Load_R3,
    input  Load_PC, Inc_PC, Sel_Bus_1_Mux, Sel_Bus_2_Mux,
    input  Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z,
    input  write, err
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle control FSM for the 8-bit processing unit.
// Ports: clk, rst (sync, active high), bus (control_unit_if.master).
// Optional CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt and set sticky err.
module control_unit #(
  parameter int word_size  = 8,
  parameter int op_size    = 4,
  parameter int state_size = 4,
  parameter int Sel1_size  = 3,
  parameter int Sel2_size  = 2
) (
  input  logic          clk,
  input  logic          rst,
  control_unit_if.master bus
);

  typedef enum logic [state_size-1:0] {
    S_idle = 4'd0,
    S_fet1 = 4'd1,
    S_fet2 = 4'd2,
    S_dec  = 4'd3,
    S_ex1  = 4'd4,
    S_rd1  = 4'd5,
    S_rd2  = 4'd6,
    S_wr1  = 4'd7,
    S_wr2  = 4'd8,
    S_br1  = 4'd9,
    S_br2  = 4'd10,
    S_halt = 4'd11
  } state_t;

  localparam logic [op_size-1:0] OP_NOP  = 4'd0;
  localparam logic [op_size-1:0] OP_ADD  = 4'd1;
  localparam logic [op_size-1:0] OP_SUB  = 4'd2;
  localparam logic [op_size-1:0] OP_AND  = 4'd3;
  localparam logic [op_size-1:0] OP_NOT  = 4'd4;
  localparam logic [op_size-1:0] OP_RD   = 4'd5;
  localparam logic [op_size-1:0] OP_WR   = 4'd6;
  localparam logic [op_size-1:0] OP_BR   = 4'd7;
  localparam logic [op_size-1:0] OP_BRZ  = 4'd8;
  localparam logic [op_size-1:0] OP_HALT = 4'd15;

  localparam logic [Sel1_size-1:0] B1_PC   = 3'd4;
  localparam logic [Sel2_size-1:0] B2_ALU  = 2'd0;
  localparam logic [Sel2_size-1:0] B2_BUS1 = 2'd1;
  localparam logic [Sel2_size-1:0] B2_MEM  = 2'd2;

  state_t state, nxt;

  logic [op_size-1:0]   op;
  logic [1:0]           src;
  logic [1:0]           dst;
  logic                 ld_dest;
  logic                 ld_pc;
  logic                 inc_pc;
  logic [Sel1_size-1:0] s1;
  logic [Sel2_size-1:0] s2;
  logic                 ld_ir;
  logic                 ld_ar;
  logic                 ld_y;
  logic                 ld_z;
  logic                 wr;
  logic [3:0]           ld_r;

  assign op  = bus.instruction[word_size-1 -: op_size];
  assign src = bus.instruction[3:2];
  assign dst = bus.instruction[1:0];

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic trap;
  logic err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_idle;
    else     state <= nxt;
  end

  always_comb begin
    nxt     = S_idle;
    ld_dest = 1'b0;
    ld_pc   = 1'b0;
    inc_pc  = 1'b0;
    s1      = '0;
    s2      = '0;
    ld_ir   = 1'b0;
    ld_ar   = 1'b0;
    ld_y    = 1'b0;
    ld_z    = 1'b0;
    wr      = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    trap    = 1'b0;
`endif
    case (state)
      S_idle: nxt = S_fet1;
      S_fet1: begin
        s1 = B1_PC; s2 = B2_BUS1;
        ld_ar = 1'b1; inc_pc = 1'b1;
        nxt = S_fet2;
      end
      S_fet2: begin
        s2 = B2_MEM; ld_ir = 1'b1;
        nxt = S_dec;
      end
      S_dec: begin
        case (op)
          OP_NOP: nxt = S_fet1;
          OP_ADD, OP_SUB, OP_AND: begin
            s1 = Sel1_size'(src); s2 = B2_BUS1;
            ld_y = 1'b1;
            nxt = S_ex1;
          end
          OP_NOT: begin
            s1 = Sel1_size'(src); s2 = B2_ALU;
            ld_z = 1'b1; ld_dest = 1'b1;
            nxt = S_fet1;
          end
          OP_RD: begin
            s1 = B1_PC; s2 = B2_BUS1; ld_ar = 1'b1;
            nxt = S_rd1;
          end
          OP_WR: begin
            s1 = B1_PC; s2 = B2_BUS1; ld_ar = 1'b1;
            nxt = S_wr1;
          end
          OP_BR: begin
            s1 = B1_PC; s2 = B2_BUS1; ld_ar = 1'b1;
            nxt = S_br1;
          end
          OP_BRZ: begin
            if (bus.Zflag) begin
              s1 = B1_PC; s2 = B2_BUS1; ld_ar = 1'b1;
              nxt = S_br1;
            end else begin
              // untaken: step PC past the target byte
              inc_pc = 1'b1;
              nxt = S_fet1;
            end
          end
          OP_HALT: nxt = S_halt;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            trap = 1'b1;
            nxt  = S_halt;
`else
            nxt  = S_fet1;
`endif
          end
        endcase
      end
      S_ex1: begin
        s1 = Sel1_size'(dst); s2 = B2_ALU;
        ld_z = 1'b1; ld_dest = 1'b1;
        nxt = S_fet1;
      end
      S_rd1: begin
        s2 = B2_MEM; ld_ar = 1'b1; inc_pc = 1'b1;
        nxt = S_rd2;
      end
      S_rd2: begin
        s2 = B2_MEM; ld_dest = 1'b1;
        nxt = S_fet1;
      end
      S_wr1: begin
        s2 = B2_MEM; ld_ar = 1'b1; inc_pc = 1'b1;
        nxt = S_wr2;
      end
      S_wr2: begin
        s1 = Sel1_size'(src); wr = 1'b1;
        nxt = S_fet1;
      end
      S_br1: begin
        s2 = B2_MEM; ld_ar = 1'b1;
        nxt = S_br2;
      end
      S_br2: begin
        s2 = B2_MEM; ld_pc = 1'b1;
        nxt = S_fet1;
      end
      S_halt: nxt = S_halt;
      default: nxt = S_idle;
    endcase
    // reset kills every strobe in the same cycle
    if (rst) begin
      ld_dest = 1'b0;
      ld_pc   = 1'b0;
      inc_pc  = 1'b0;
      s1      = '0;
      s2      = '0;
      ld_ir   = 1'b0;
      ld_ar   = 1'b0;
      ld_y    = 1'b0;
      ld_z    = 1'b0;
      wr      = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      trap    = 1'b0;
`endif
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst)       err_q <= 1'b0;
    else if (trap) err_q <= 1'b1;
  end
  assign bus.err = err_q & ~rst;
`else
  assign bus.err = 1'b0;
`endif

  assign ld_r = ld_dest ? (4'b0001 << dst) : 4'b0000;

  assign bus.Load_R0       = ld_r[0];
  assign bus.Load_R1       = ld_r[1];
  assign bus.Load_R2       = ld_r[2];
  assign bus.Load_R3       = ld_r[3];
  assign bus.Load_PC       = ld_pc;
  assign bus.Inc_PC        = inc_pc;
  assign bus.Sel_Bus_1_Mux = s1;
  assign bus.Sel_Bus_2_Mux = s2;
  assign bus.Load_IR       = ld_ir;
  assign bus.Load_Add_R    = ld_ar;
  assign bus.Load_Reg_Y    = ld_y;
  assign bus.Load_Reg_Z    = ld_z;
  assign bus.write         = wr;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction micro-step model.
// Directed plan steps followed by a random instruction stream.
module tb_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  control_unit_if bus ();

  control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0] ld_r;
    logic       ld_pc;
    logic       inc_pc;
    logic [2:0] s1;
    logic [1:0] s2;
    logic       ld_ir;
    logic       ld_ar;
    logic       ld_y;
    logic       ld_z;
    logic       wr;
    logic       err;
  } ctrl_t;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int last_fet = -1;
  int exp_gap  = 0;

  function automatic ctrl_t observe();
    ctrl_t r;
    r.ld_r   = {bus.Load_R3, bus.Load_R2, bus.Load_R1, bus.Load_R0};
    r.ld_pc  = bus.Load_PC;
    r.inc_pc = bus.Inc_PC;
    r.s1     = bus.Sel_Bus_1_Mux;
    r.s2     = bus.Sel_Bus_2_Mux;
    r.ld_ir  = bus.Load_IR;
    r.ld_ar  = bus.Load_Add_R;
    r.ld_y   = bus.Load_Reg_Y;
    r.ld_z   = bus.Load_Reg_Z;
    r.wr     = bus.write;
    r.err    = bus.err;
    return r;
  endfunction

  // fetch-to-fetch distance by instruction class
  function automatic int latency(logic [3:0] op, logic z);
    case (op)
      4'd0, 4'd4:       return 3;
      4'd1, 4'd2, 4'd3: return 4;
      4'd5, 4'd6, 4'd7: return 5;
      4'd8:             return z ? 5 : 3;
      4'd15:            return 0;
      default:          return TRAP ? 0 : 3;
    endcase
  endfunction

  // one clock: drive Zflag, compare at negedge, advance to posedge+1
  task automatic cycle(string tag, ctrl_t exp, logic z);
    ctrl_t obs;
    bus.Zflag = z;
    @(negedge clk);
    obs = observe();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h exp %h", tag, obs, exp);
    end
    checks++;
    assert ($countones(obs.ld_r) <= 1) else begin
      errors++;
      $error("FAIL %s_onehot: got %b exp <=1 set", tag, obs.ld_r);
    end
    checks++;
    assert (!(obs.ld_pc && obs.inc_pc)) else begin
      errors++;
      $error("FAIL %s_pcx: got 11 exp not both", tag);
    end
    if (obs.ld_ar && obs.inc_pc && obs.s1 == 3'd4) begin
      if (exp_gap > 0) begin
        checks++;
        assert (cyc - last_fet === exp_gap) else begin
          errors++;
          $error("FAIL %s_gap: got %0d exp %0d",
                 tag, cyc - last_fet, exp_gap);
        end
      end
      last_fet = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) cycle("reset", '0, 1'($urandom));
    rst = 1'b0;
    exp_gap  = 0;
    last_fet = -1;
    cycle("idle", '0, 1'($urandom));
  endtask

  // limit >= 0 aborts with a reset after that many cycles
  task automatic run_instr(logic [7:0] ins, logic z, int limit);
    ctrl_t q[$];
    ctrl_t c;
    ctrl_t h;
    bit halt;
    logic [3:0] op;
    logic [2:0] src;
    logic [2:0] dst;
    logic [3:0] dm;
    op   = ins[7:4];
    src  = {1'b0, ins[3:2]};
    dst  = {1'b0, ins[1:0]};
    dm   = 4'b0001 << ins[1:0];
    halt = 1'b0;
    h    = '0;
    bus.instruction = ins;
    c = '0; c.s1 = 3'd4; c.s2 = 2'd1; c.ld_ar = 1; c.inc_pc = 1;
    q.push_back(c);
    c = '0; c.s2 = 2'd2; c.ld_ir = 1;
    q.push_back(c);
    c = '0;
    case (op)
      4'd0: q.push_back(c);
      4'd1, 4'd2, 4'd3: begin
        c.s1 = src; c.s2 = 2'd1; c.ld_y = 1;
        q.push_back(c);
        c = '0; c.s1 = dst; c.ld_z = 1; c.ld_r = dm;
        q.push_back(c);
      end
      4'd4: begin
        c.s1 = src; c.ld_z = 1; c.ld_r = dm;
        q.push_back(c);
      end
      4'd5, 4'd6, 4'd7, 4'd8: begin
        if (op == 4'd8 && !z) begin
          c.inc_pc = 1;
          q.push_back(c);
        end else begin
          c.s1 = 3'd4; c.s2 = 2'd1; c.ld_ar = 1;
          q.push_back(c);
          c = '0;
          if (op == 4'd5 || op == 4'd6) begin
            c.s2 = 2'd2; c.ld_ar = 1; c.inc_pc = 1;
            q.push_back(c);
            c = '0;
            if (op == 4'd5) begin
              c.s2 = 2'd2; c.ld_r = dm;
            end else begin
              c.s1 = src; c.wr = 1;
            end
            q.push_back(c);
          end else begin
            c.s2 = 2'd2; c.ld_ar = 1;
            q.push_back(c);
            c = '0; c.s2 = 2'd2; c.ld_pc = 1;
            q.push_back(c);
          end
        end
      end
      4'd15: begin
        q.push_back(c);
        halt = 1'b1;
      end
      default: begin
        q.push_back(c);
        halt = TRAP;
        h.err = TRAP;
      end
    endcase
    for (int i = 0; i < q.size(); i++) begin
      if (limit >= 0 && i >= limit) begin
        do_reset();
        return;
      end
      cycle($sformatf("i%02h_c%0d", ins, i), q[i],
            (i == 2) ? z : 1'($urandom));
    end
    exp_gap = latency(op, z);
    if (halt) begin
      for (int i = 0; i < 3; i++)
        cycle($sformatf("i%02h_halt%0d", ins, i), h, 1'($urandom));
      do_reset();
    end
  endtask

  initial begin
    bus.instruction = 8'h00;
    bus.Zflag       = 1'b0;
    #1;
    do_reset();
    run_instr(8'h16, 1'b0, -1);
    run_instr(8'h53, 1'b1, -1);
    run_instr(8'h64, 1'b0, -1);
    run_instr(8'h80, 1'b0, -1);
    run_instr(8'h80, 1'b1, -1);
    run_instr(8'h7c, 1'b0, -1);
    run_instr(8'h49, 1'b1, -1);
    run_instr(8'h2e, 1'b0, -1);
    run_instr(8'h33, 1'b1, -1);
    run_instr(8'h00, 1'b0, -1);
    run_instr(8'h65, 1'b0, 3);
    run_instr(8'h9a, 1'b0, -1);
    run_instr(8'h16, 1'b0, -1);
    for (int n = 0; n < 200; n++)
      run_instr(8'($urandom), 1'($urandom), -1);
    run_instr(8'hf0, 1'b0, -1);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
